// File: rtl/alu_core.sv
// Multi-cycle ALU behind a start/done handshake. Add/and/xor finish one cycle
// after capture; mul runs a DATA_W-step shift-add before pulsing done.
module alu_core #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_W-1:0]     A,
  input  logic [DATA_W-1:0]     B,
  input  logic [2:0]            op,
  input  logic                  start,
  output logic                  done,
  output logic [2*DATA_W-1:0]   result
);

  localparam int RW    = 2 * DATA_W;
  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;
  localparam logic [2:0] OP_RST = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [RW-1:0]      a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic [RW-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]      result_q, result_d;
  logic               done_q, done_d;

  logic [DATA_W:0]    sum;
  logic [RW-1:0]      acc_next;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;

    sum      = {1'b0, a_q[DATA_W-1:0]} + {1'b0, b_q};
    acc_next = acc_q + (b_q[0] ? a_q : '0);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = RW'(A);
          b_d     = B;
          op_d    = op;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = (op == OP_MUL) ? S_MUL : S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (op_q)
          OP_ADD:  result_d = RW'(sum);
          OP_AND:  result_d = RW'(a_q[DATA_W-1:0] & b_q);
          OP_XOR:  result_d = RW'(a_q[DATA_W-1:0] ^ b_q);
          OP_RST:  result_d = '0;
          default: result_d = result_q;
        endcase
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_MUL: begin
        // multiplicand shifts left while the multiplier shifts right, so the
        // LSB of b_q is always the bit being processed this edge
        acc_d = acc_next;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          result_d = acc_next;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- Multi-cycle 8-bit ALU that responds to the start/done handshake driven by the testbench ALU bus-functional interface.
- Captures A, B and op when start is seen idle, computes, then pulses done with result held stable.
- Single-cycle path for add/and/xor; iterative shift-add multiplier for mul.
- Sits as the DUT under the tb0_alu UVM environment.

Parameters:
- DATA_W, 8, operand width; result width is 2*DATA_W; mul iteration count equals DATA_W.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- A  input  DATA_W  operand A, unsigned.
- B  input  DATA_W  operand B, unsigned.
- op  input  3  opcode: 0 no_op, 1 add, 2 and, 3 xor, 4 mul, 5/6 reserved, 7 rst_op.
- start  input  1  request; held high by the initiator until done is observed.
- done  output  1  one-cycle completion pulse.
- result  output  2*DATA_W  operation result.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, done=0, result=0, internal operand, accumulator and counter registers=0.
- States: IDLE, EXEC, MUL, DONE.
- IDLE:
  - On a rising edge E0 with start=1, latch A, B and op.
  - Go to MUL if op=4, else EXEC.
  - start=0 means stay in IDLE.
- EXEC, at edge E1:
  - add: result = zero-extended 9-bit A+B. Carry lands in bit 8; bits 15:9 are 0.
  - and: result = {8'h00, A&B}.
  - xor: result = {8'h00, A^B}.
  - no_op or reserved 5/6: result unchanged.
  - rst_op: result = 0.
  - In every case done=1 and state goes to DONE. Latency is 1 cycle after the capture edge.
- MUL, unsigned shift-add:
  - Accumulator is cleared at E0.
  - On edges E1..E_DATA_W, process one multiplier bit per edge, LSB first.
  - At edge E_DATA_W (E8 by default): result = full 16-bit product, done=1, state goes to DONE.
  - result keeps its previous value during E1..E7.
- DONE:
  - done is high for exactly this one cycle.
  - At the next edge: done=0, state goes to IDLE.
  - start is ignored in DONE.
- Busy: start, A, B and op changes during EXEC, MUL or DONE are ignored; operands are captured only at E0.
- Hold start: if start is still high in IDLE after DONE, a new operation is captured using the current A, B and op. The initiator must drop start after done to avoid this.
- result holds its value between operations. Only EXEC, MUL completion or reset change it.
- Reset mid-operation: the operation is aborted immediately, no done pulse occurs, and outputs take their reset values.
- Arithmetic: all unsigned; no overflow flag. FF*FF = FE01; FF+01 = 0100.

Test Plan:
- Reset, then add A=8'hFF, B=8'h01 with start at E0 -> done=1 for one cycle after E1, result=16'h0100, then done=0.
- and A=8'hF0, B=8'h3C -> result 16'h0030. Then xor with the same operands -> result 16'h00CC. Each has 1-cycle latency.
- mul A=8'hFF, B=8'hFF -> done only after E8, result=16'hFE01. Changing A/B while busy must not affect the result. mul A=0, B=8'h55 -> 16'h0000.
- no_op after an add that gave 16'h0100 -> done pulses, result stays 16'h0100. Then rst_op -> done pulses, result=16'h0000.
- Deassert reset_n at E4 of a mul -> done and result go to 0 asynchronously, with no done pulse. After release, add 3+4 -> 16'h0007.
- Back-to-back: the initiator drops start on the negedge after done, then reissues.
  - Ops add 1+1, then mul 2*3, then xor 5^5 -> results 0002, 0006, 0000.
  - Exactly one done pulse per operation.
